elastic_pipe_reg: RTL and testbench
===================================

// Module: elastic_pipe_reg
// PURPOSE
//  Parametrised multi-stage pipeline register with a valid/ready handshake per beat.
//  Generalises the single D-FF to WIDTH-bit data, DEPTH stages, backpressure,
//  bubble collapse, flush and selectable data-reset mode.
//  Used as the standard retiming / elastic buffering stage between datapath blocks.
// PARAMETERS
//  WIDTH     8     data width in bits (>=1)
//  DEPTH     4     number of register stages (>=1)
//  DATA_RST  0     0: data regs not reset (valid bits only); 1: data regs reset to RST_VAL
//  RST_VAL   '0    data reset value, used only when DATA_RST=1
// PORTS
//  clk          in   1                  clock, all state updates on rising edge
//  reset        in   1                  synchronous, active-high reset
//  flush_i      in   1                  sync flush: drop all held beats
//  in_valid_i   in   1                  upstream beat valid
//  in_data_i    in   WIDTH              upstream beat data
//  in_ready_o   out  1                  pipe accepts a beat this cycle
//  out_valid_o  out  1                  beat at last stage valid
//  out_data_o   out  WIDTH              last-stage data
//  out_ready_i  in   1                  downstream accepts beat
//  count_o      out  $clog2(DEPTH+1)    number of valid stages held
// BEHAVIOUR
//  - Stages s0..s(DEPTH-1), each = {vld[i], dat[i]}. out_valid_o=vld[DEPTH-1], out_data_o=dat[DEPTH-1].
//  - Advance: adv[DEPTH-1] = !vld[DEPTH-1] | out_ready_i; adv[i] = !vld[i] | adv[i+1].
//  - in_ready_o = adv[0] & !flush_i & !reset (combinational; ripples from out_ready_i).
//  - Input handshake: in_valid_i & in_ready_o. Output handshake: out_valid_o & out_ready_i.
//  - On edge where adv[i]: vld[i] <= src valid (s0: in_valid_i & in_ready_o; si: vld[i-1]);
//    dat[i] <= src data only when src valid=1, else dat[i] holds.
//  - Stage with !adv[i] holds vld and dat unchanged (stall).
//  - Bubble collapse: an empty stage always accepts from upstream, even if downstream stalled.
//  - Latency: beat accepted on edge k is at output (out_valid_o=1) after edge k+DEPTH-1
//    when no stalls; DEPTH=1 -> visible right after edge k.
//  - Throughput: 1 beat/cycle with out_ready_i=1 continuously; full with DEPTH beats stalled.
//  - Ordering: beats leave in acceptance order; no loss, no duplication.
//  - count_o: registered, always equals popcount(vld); +1 on input hs, -1 on output hs,
//    unchanged when both/neither occur in the same cycle.
//  - Full (count_o=DEPTH) & out_ready_i=0 -> in_ready_o=0. Full & out_ready_i=1 -> in_ready_o=1
//    (simultaneous push/pop, count unchanged).
//  - Empty: out_valid_o=0, out_data_o undefined unless DATA_RST=1.
//  - flush_i=1: output handshake in that cycle still completes; input not accepted;
//    next edge: all vld=0, count_o=0. dat regs unchanged.
//  - reset=1 (priority over flush_i): next edge all vld=0, count_o=0; dat=RST_VAL if DATA_RST=1,
//    else dat untouched. in_ready_o=0 while reset high. Mid-operation reset discards held beats.
//  - After reset deasserts: in_ready_o=1 same cycle (pipe empty).
// TESTING
//  1 reset 2 cycles, DATA_RST=1, RST_VAL=8'hA5 -> out_valid_o=0, count_o=0, in_ready_o=0 in reset, out_data_o=8'hA5.
//  2 DEPTH=4, push 8'h01..8'h08 back-to-back, out_ready_i=1 -> first out_valid_o 3 edges after first accept, 01..08 contiguous, count_o=4 steady.
//  3 out_ready_i=0, offer 6 beats 8'h01..8'h06 -> only 01..04 accepted, in_ready_o=0, count_o=4; then out_ready_i=1 -> 01..04 in order, then 05,06.
//  4 out_ready_i=0, push 8'h11, idle 2 cycles, push 8'h22 -> both held in s3,s2, count_o=2, in_ready_o stays 1.
//  5 3 beats held, flush_i 1 cycle with in_valid_i=1 -> in_ready_o=0 that cycle, next cycle count_o=0, out_valid_o=0.
//  6 Pipe full, out_ready_i=0, reset 1 cycle -> next cycle count_o=0, out_valid_o=0, in_ready_o=1 after release.

Source files
------------

// File: rtl/elastic_pipe_reg.sv
// Elastic multi-stage pipeline register with per-beat valid/ready handshake, flush and optional data reset.
// Latency: DEPTH-1 cycles from accept edge to out_valid_o when unstalled (DEPTH=1 -> visible right after the accept edge).
// Backpressure: out_ready_i ripples combinationally to in_ready_o; empty stages always fill (bubble collapse).
module elastic_pipe_reg #(
   parameter int unsigned      WIDTH    = 8,
   parameter int unsigned      DEPTH    = 4,
   parameter bit               DATA_RST = 1'b0,
   parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush_i,
   input  logic                       in_valid_i,
   input  logic [WIDTH-1:0]           in_data_i,
   output logic                       in_ready_o,
   output logic                       out_valid_o,
   output logic [WIDTH-1:0]           out_data_o,
   input  logic                       out_ready_i,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);

   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [DEPTH-1:0] vld;
   logic [WIDTH-1:0] dat [DEPTH];
   logic [DEPTH-1:0] adv;
   logic [DEPTH-1:0] src_vld;
   logic [WIDTH-1:0] src_dat [DEPTH];
   logic             in_hs;
   logic             out_hs;

   // A stage may move when it is empty or when the stage after it moves; walk from the output back.
   always_comb begin
      logic chain;
      chain = out_ready_i;
      adv   = '0;
      for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
         chain  = !vld[i] | chain;
         adv[i] = chain;
      end
   end

   // Source of each stage: the input port for s0, the preceding stage otherwise.
   always_comb begin
      src_vld    = '0;
      src_vld[0] = in_hs;
      src_dat[0] = in_data_i;
      for (int i = 1; i < int'(DEPTH); i++) begin
         src_vld[i] = vld[i-1];
         src_dat[i] = dat[i-1];
      end
   end

   assign in_ready_o  = adv[0] & !flush_i & !reset;
   assign in_hs       = in_valid_i & in_ready_o;
   assign out_hs      = vld[DEPTH-1] & out_ready_i;
   assign out_valid_o = vld[DEPTH-1];
   assign out_data_o  = dat[DEPTH-1];

   // Valid bits: cleared by reset/flush, otherwise loaded from upstream when the stage advances.
   always_ff @(posedge clk) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
         if (reset || flush_i) begin
            vld[i] <= 1'b0;
         end else if (adv[i]) begin
            vld[i] <= src_vld[i];
         end
      end
   end

   // Data regs only capture real beats so a bubble never overwrites held data; flush leaves them alone.
   always_ff @(posedge clk) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
         if (reset) begin
            if (DATA_RST) begin
               dat[i] <= RST_VAL;
            end
         end else if (!flush_i && adv[i] && src_vld[i]) begin
            dat[i] <= src_dat[i];
         end
      end
   end

   // Occupancy tracks handshakes rather than re-counting vld, keeping it off the adv ripple path.
   always_ff @(posedge clk) begin
      if (reset || flush_i) begin
         count_o <= '0;
      end else begin
         count_o <= count_o + CW'(in_hs) - CW'(out_hs);
      end
   end

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// Scoreboard bench for elastic_pipe_reg: directed scenarios followed by random traffic.
// Latency: n/a (testbench).
// Backpressure: random and directed out_ready_i stalls.
module tb_elastic_pipe_reg;

   localparam int DEPTH = 4;
   localparam int WIDTH = 8;
   localparam logic [WIDTH-1:0] RSTV = 8'hA5;

   logic             clk;
   logic             reset;
   logic             flush_i;
   logic             in_valid_i;
   logic [WIDTH-1:0] in_data_i;
   logic             in_ready_o;
   logic             out_valid_o;
   logic [WIDTH-1:0] out_data_o;
   logic             out_ready_i;
   logic [2:0]       count_o;

   elastic_pipe_reg #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .DATA_RST(1'b1), .RST_VAL(RSTV)
   ) dut (
      .clk(clk), .reset(reset), .flush_i(flush_i),
      .in_valid_i(in_valid_i), .in_data_i(in_data_i), .in_ready_o(in_ready_o),
      .out_valid_o(out_valid_o), .out_data_o(out_data_o), .out_ready_i(out_ready_i),
      .count_o(count_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_cmp  = 0;
   int n_fail = 0;
   int cyc    = 0;

   typedef struct {
      logic [WIDTH-1:0] d;
      int               acc;
   } beat_t;
   beat_t q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: a FIFO of accepted beats, each stamped with its accept cycle.
   // A beat is at the output once it is the oldest held and DEPTH edges have passed since acceptance.
   always @(negedge clk) begin
      logic  exp_rdy;
      logic  exp_vld;
      beat_t b;
      exp_rdy = !reset && !flush_i && ((q.size() < DEPTH) || out_ready_i);
      exp_vld = (q.size() > 0) && ((cyc - q[0].acc) >= DEPTH);
      chk("count_o", 32'(count_o), 32'(q.size()));
      chk("in_ready_o", 32'(in_ready_o), 32'(exp_rdy));
      chk("out_valid_o", 32'(out_valid_o), 32'(exp_vld));
      if (exp_vld) begin
         chk("out_data_o", 32'(out_data_o), 32'(q[0].d));
      end
      if (!reset && exp_vld && out_ready_i) begin
         void'(q.pop_front());
      end
      if (in_valid_i && exp_rdy) begin
         b.d   = in_data_i;
         b.acc = cyc;
         q.push_back(b);
      end
      if (reset || flush_i) begin
         q.delete();
      end
      cyc++;
   end

   // One cycle of stimulus, applied just after the rising edge.
   task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic ordy,
                        input logic fl, input logic rst);
      @(posedge clk);
      #2;
      in_valid_i  = v;
      in_data_i   = d;
      out_ready_i = ordy;
      flush_i     = fl;
      reset       = rst;
   endtask

   // Offer one beat until it is accepted, bounded by maxc cycles.
   task automatic send(input logic [WIDTH-1:0] d, input logic ordy, input int maxc);
      bit done;
      done = 1'b0;
      for (int i = 0; i < maxc && !done; i++) begin
         drive(1'b1, d, ordy, 1'b0, 1'b0);
         #1;
         done = in_ready_o;
      end
      if (!done) begin
         n_cmp++;
         n_fail++;
         $display("FAIL send_timeout: got no accept, expected accept of %0h within %0d cycles", d, maxc);
      end
   endtask

   task automatic idle(input logic ordy, input int n);
      for (int i = 0; i < n; i++) drive(1'b0, '0, ordy, 1'b0, 1'b0);
   endtask

   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   initial begin
      reset       = 1'b1;
      flush_i     = 1'b0;
      in_valid_i  = 1'b0;
      in_data_i   = '0;
      out_ready_i = 1'b1;

      // Reset for two cycles: pipe empty, not ready, data at reset value.
      drive(1'b0, '0, 1'b1, 1'b0, 1'b1);
      settle();
      chk("rst_in_ready", 32'(in_ready_o), 32'd0);
      chk("rst_out_valid", 32'(out_valid_o), 32'd0);
      chk("rst_count", 32'(count_o), 32'd0);
      chk("rst_out_data", 32'(out_data_o), 32'(RSTV));
      drive(1'b0, '0, 1'b1, 1'b0, 1'b1);
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
      #1;
      chk("post_rst_in_ready", 32'(in_ready_o), 32'd1);

      // Back-to-back stream with downstream always ready.
      for (int i = 1; i <= 8; i++) send(8'(i), 1'b1, 4);
      idle(1'b1, DEPTH + 2);

      // Fill under stall, then drain in order.
      for (int i = 1; i <= 4; i++) send(8'(i), 1'b0, 4);
      for (int i = 0; i < 3; i++) drive(1'b1, 8'h05, 1'b0, 1'b0, 1'b0);
      settle();
      chk("full_in_ready", 32'(in_ready_o), 32'd0);
      chk("full_count", 32'(count_o), 32'd4);
      send(8'h05, 1'b1, 4);
      send(8'h06, 1'b1, 4);
      idle(1'b1, DEPTH + 3);

      // Bubble collapse: two beats with a gap stack at the output end.
      send(8'h11, 1'b0, 4);
      idle(1'b0, 2);
      send(8'h22, 1'b0, 4);
      idle(1'b0, 4);
      settle();
      chk("collapse_count", 32'(count_o), 32'd2);
      chk("collapse_in_ready", 32'(in_ready_o), 32'd1);
      chk("collapse_head", 32'(out_data_o), 32'h11);
      idle(1'b1, DEPTH + 2);

      // Flush with a beat offered.
      for (int i = 0; i < 3; i++) send(8'h30 + 8'(i), 1'b0, 4);
      drive(1'b1, 8'h3F, 1'b0, 1'b1, 1'b0);
      #1;
      chk("flush_in_ready", 32'(in_ready_o), 32'd0);
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
      #1;
      chk("flush_count", 32'(count_o), 32'd0);
      chk("flush_out_valid", 32'(out_valid_o), 32'd0);

      // Full pipe, reset mid-operation.
      for (int i = 0; i < 4; i++) send(8'h40 + 8'(i), 1'b0, 4);
      drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
      #1;
      chk("rst2_count", 32'(count_o), 32'd0);
      chk("rst2_out_valid", 32'(out_valid_o), 32'd0);
      chk("rst2_in_ready", 32'(in_ready_o), 32'd1);
      chk("rst2_out_data", 32'(out_data_o), 32'(RSTV));

      // Random traffic with occasional flush and reset.
      for (int i = 0; i < 2000; i++) begin
         drive(1'($urandom_range(0, 99) < 60), 8'($urandom), 1'($urandom_range(0, 99) < 65),
               1'($urandom_range(0, 99) < 2), 1'($urandom_range(0, 199) < 1));
      end
      idle(1'b1, DEPTH + 4);
      settle();
      chk("final_drain", 32'(q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got no end of test, expected finish before 400000 ns");
      $fatal(1, "watchdog expired");
   end

endmodule
